// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: writeback source selects, load funct3 codes and
// writeback FSM states.
package rv32i_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_NONE = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_extract.sv
// Load data alignment: picks the addressed byte/halfword out of an aligned
// memory word and sign- or zero-extends it. Purely combinational.
module load_extract
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    // Halfword loads ignore addr[0]; misaligned halves are not split.
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    result   = rdata;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// RV32I writeback stage driving the register file write port.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
//
// state     | meaning
// IDLE      | ready to accept; ALU/PC+4 results written next cycle
// WAIT_LOAD | load accepted, waiting for dmem_rvalid, flush or timeout
module regfile_writeback
  import rv32i_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [2:0]      in_funct3,
  input  logic            flush,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      wright_reg,
  output logic [XLEN-1:0] wright_data,
  output logic            wright_en,
  output logic            busy,
  output logic            load_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_count
`endif
);

  localparam logic [15:0] TO_LAST = 16'(LOAD_TIMEOUT - 1);

  wb_state_t       state, state_nxt;
  logic [15:0]     cnt, cnt_nxt;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_addr;
  logic [XLEN-1:0] ext_data;
  logic            accept;
  logic            latch_load;
  logic            wr_fire;
  logic [4:0]      wr_reg_nxt;
  logic [XLEN-1:0] wr_data_nxt;
  logic            err_nxt;

  assign in_ready = (state == IDLE);
  assign busy     = (state == WAIT_LOAD);
  assign accept   = in_valid && in_ready && !flush;

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .funct3 (ld_f3),
    .addr   (ld_addr),
    .rdata  (dmem_rdata),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    latch_load  = 1'b0;
    wr_fire     = 1'b0;
    wr_reg_nxt  = wright_reg;
    wr_data_nxt = wright_data;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (in_wb_sel)
            WB_SEL_ALU: begin
              wr_fire     = 1'b1;
              wr_reg_nxt  = in_rd;
              wr_data_nxt = in_alu_result;
            end
            WB_SEL_PC4: begin
              wr_fire     = 1'b1;
              wr_reg_nxt  = in_rd;
              wr_data_nxt = in_pc4;
            end
            WB_SEL_LOAD: begin
              latch_load = 1'b1;
              cnt_nxt    = '0;
              state_nxt  = WAIT_LOAD;
            end
            default: ;
          endcase
        end
      end
      WAIT_LOAD: begin
        // Flush has priority over a response arriving in the same cycle.
        if (flush) begin
          state_nxt = IDLE;
        end else if (dmem_rvalid) begin
          wr_fire     = 1'b1;
          wr_reg_nxt  = ld_rd;
          wr_data_nxt = ext_data;
          state_nxt   = IDLE;
        end else if (cnt == TO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      ld_rd       <= '0;
      ld_f3       <= '0;
      ld_addr     <= '0;
      wright_en   <= 1'b0;
      wright_reg  <= '0;
      wright_data <= '0;
      load_err    <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (latch_load) begin
        ld_rd   <= in_rd;
        ld_f3   <= in_funct3;
        ld_addr <= in_alu_result[1:0];
      end
      // x0 is never written, but the address/data still track the result.
      wright_en   <= wr_fire && (wr_reg_nxt != 5'd0);
      wright_reg  <= wr_reg_nxt;
      wright_data <= wr_data_nxt;
      load_err    <= err_nxt;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic retire_inc;

  assign retire_inc = (accept && (in_wb_sel != WB_SEL_LOAD))
                    || ((state == WAIT_LOAD) && !flush && dmem_rvalid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            retire_count <= '0;
    else if (retire_inc) retire_count <= retire_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_regfile_writeback;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc4;
  logic [2:0]  in_funct3;
  logic        flush;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  wright_reg;
  logic [31:0] wright_data;
  logic        wright_en;
  logic        busy;
  logic        load_err;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  always #5 clk = ~clk;

  regfile_writeback #(.XLEN(32), .LOAD_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_wb_sel     (in_wb_sel),
    .in_alu_result (in_alu_result),
    .in_pc4        (in_pc4),
    .in_funct3     (in_funct3),
    .flush         (flush),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wright_reg    (wright_reg),
    .wright_data   (wright_data),
    .wright_en     (wright_en),
    .busy          (busy),
    .load_err      (load_err)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count  (retire_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: one pending-load record plus the last write seen.
  bit          m_busy;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  int unsigned m_addr;
  int          m_wait;
  logic        m_wen;
  logic        m_err;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] m_retire;

  function automatic logic [31:0] ref_extract(input logic [2:0] f3, input int unsigned a,
                                              input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rd = '0; m_f3 = '0; m_addr = 0; m_wait = 0;
    m_wen = 0; m_err = 0; m_wreg = '0; m_wdata = '0; m_retire = '0;
  endtask

  task automatic ref_write(input logic [4:0] rd, input logic [31:0] v);
    m_wreg   = rd;
    m_wdata  = v;
    m_wen    = (rd != 5'd0);
    m_retire = m_retire + 32'd1;
  endtask

  task automatic model_step();
    m_wen = 0;
    m_err = 0;
    if (!m_busy) begin
      if (in_valid && !flush) begin
        case (in_wb_sel)
          2'b00: ref_write(in_rd, in_alu_result);
          2'b10: ref_write(in_rd, in_pc4);
          2'b01: begin
            m_busy = 1; m_rd = in_rd; m_f3 = in_funct3;
            m_addr = in_alu_result % 4; m_wait = 0;
          end
          default: m_retire = m_retire + 32'd1;
        endcase
      end
    end else if (flush) begin
      m_busy = 0;
    end else if (dmem_rvalid) begin
      ref_write(m_rd, ref_extract(m_f3, m_addr, dmem_rdata));
      m_busy = 0;
    end else begin
      m_wait++;
      if (m_wait >= TO) begin
        m_busy = 0;
        m_err  = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("wright_en",   32'(wright_en),  32'(m_wen));
    chk("wright_reg",  32'(wright_reg), 32'(m_wreg));
    chk("wright_data", wright_data,     m_wdata);
    chk("busy",        32'(busy),       32'(m_busy));
    chk("in_ready",    32'(in_ready),   32'(!m_busy));
    chk("load_err",    32'(load_err),   32'(m_err));
`ifdef WB_RETIRE_CNT_EN
    chk("retire_count", retire_count, m_retire);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic quiet();
    in_valid = 0; flush = 0; dmem_rvalid = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [2:0] f3);
    in_valid = 1; in_rd = rd; in_wb_sel = sel;
    in_alu_result = alu; in_pc4 = pc4; in_funct3 = f3;
    tick();
    in_valid = 0;
  endtask

  initial begin
    int busy_cycles;
    int err_pulses;
    int to_cycles;
    logic [31:0] r0;

    rst = 0;
    quiet();
    in_rd = '0; in_wb_sel = '0; in_alu_result = '0; in_pc4 = '0;
    in_funct3 = '0; dmem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1;
    @(negedge clk);
    check_outputs();

    // ALU write, then three back-to-back accepts
    issue(5'd5, 2'b00, 32'h1234_5678, 32'h0, 3'b000);
    chk("alu_en", 32'(wright_en), 32'd1);
    chk("alu_reg", 32'(wright_reg), 32'd5);
    chk("alu_data", wright_data, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_rd = 5'(10 + i); in_wb_sel = 2'b00; in_alu_result = 32'(i * 16 + 1);
      tick();
      chk("b2b_en", 32'(wright_en), 32'd1);
    end
    quiet();
    tick();

    // LB sign-extension with a 4-cycle response
    issue(5'd7, 2'b01, 32'h0000_1003, 32'h0, 3'b000);
    busy_cycles = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) busy_cycles++;
    end
    dmem_rvalid = 1; dmem_rdata = 32'h80FF_FFFF;
    tick();
    dmem_rvalid = 0;
    chk("lb_busy_cycles", 32'(busy_cycles), 32'd4);
    chk("lb_data", wright_data, 32'hFFFF_FF80);
    chk("lb_reg", 32'(wright_reg), 32'd7);

    // LHU from the upper half
    issue(5'd8, 2'b01, 32'h0000_1002, 32'h0, 3'b101);
    dmem_rvalid = 1; dmem_rdata = 32'h8001_0000;
    tick();
    dmem_rvalid = 0;
    chk("lhu_data", wright_data, 32'h0000_8001);

    // rd==0 never asserts the write enable
    r0 = m_retire;
    issue(5'd0, 2'b10, 32'h0, 32'h0000_0044, 3'b000);
    chk("rd0_en", 32'(wright_en), 32'd0);
    chk("rd0_data", wright_data, 32'h0000_0044);
    chk("rd0_retire_model", m_retire, r0 + 32'd1);

    // Flush beats a simultaneous response; flush on accept drops the instruction
    issue(5'd3, 2'b01, 32'h0000_2000, 32'h0, 3'b010);
    tick();
    flush = 1; dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    quiet();
    chk("flush_rv_en", 32'(wright_en), 32'd0);
    chk("flush_rv_ready", 32'(in_ready), 32'd1);
    flush = 1;
    issue(5'd9, 2'b00, 32'hCAFE_0001, 32'h0, 3'b000);
    quiet();
    chk("flush_acc_en", 32'(wright_en), 32'd0);

    // Timeout, then a late response that must be ignored
    issue(5'd4, 2'b01, 32'h0000_3000, 32'h0, 3'b010);
    err_pulses = 0;
    to_cycles  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (load_err) begin
        err_pulses++;
        if (to_cycles == 0) to_cycles = i + 1;
      end
    end
    chk("to_pulses", 32'(err_pulses), 32'd1);
    chk("to_cycle", 32'(to_cycles), 32'(TO));
    dmem_rvalid = 1; dmem_rdata = 32'h1111_1111;
    tick();
    dmem_rvalid = 0;
    chk("late_rvalid_en", 32'(wright_en), 32'd0);

    // Asynchronous reset in the middle of a load
    issue(5'd6, 2'b01, 32'h0000_4000, 32'h0, 3'b010);
    tick();
    #2 rst = 0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_en", 32'(wright_en), 32'd0);
    chk("arst_data", wright_data, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1;
    dmem_rvalid = 1; dmem_rdata = 32'h2222_2222;
    tick();
    dmem_rvalid = 0;
    chk("arst_after_en", 32'(wright_en), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_rd         = 5'($urandom_range(0, 31));
      in_wb_sel     = 2'($urandom_range(0, 3));
      in_alu_result = $urandom;
      in_pc4        = $urandom;
      in_funct3     = 3'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 15) == 0);
      dmem_rvalid   = ($urandom_range(0, 4) == 0);
      dmem_rdata    = $urandom;
      tick();
    end
    quiet();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
